// File: rtl/wb_queue.sv
// In-order writeback queue feeding the integer register file write port,
// with youngest-first forwarding of queued-but-unwritten results.
module wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4:0]                in_rd,
  input  logic [XLEN-1:0]           in_value,
  input  logic                      wb_stall,
  output logic                      reg_we,
  output logic [4:0]                rd,
  output logic [XLEN-1:0]           rd_value,
  input  logic [4:0]                rs1,
  input  logic [4:0]                rs2,
  output logic                      fwd1_hit,
  output logic [XLEN-1:0]           fwd1_value,
  output logic                      fwd2_hit,
  output logic [XLEN-1:0]           fwd2_value,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      idle
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]      r_rd  [DEPTH];
  logic [XLEN-1:0] r_val [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic [PW-1:0]   w_idx;

  // Writes are suppressed during reset so nothing queued escapes the reset cycle.
  assign w_empty  = (r_count == '0);
  assign w_pop    = !w_empty && !wb_stall && !rst;
  assign in_ready = (r_count < CW'(DEPTH)) || w_pop;
  assign w_push   = in_valid && in_ready && (in_rd != 5'd0) && !rst;

  assign reg_we   = w_pop;
  assign rd       = w_empty ? 5'd0 : r_rd[r_head];
  assign rd_value = w_empty ? '0   : r_val[r_head];
  assign count    = r_count;
  assign idle     = w_empty;

  // Pointers and occupancy; entry validity is derived from these alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_tail]  <= in_rd;
      r_val[r_tail] <= in_value;
    end
  end

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd1_hit   = 1'b0;
    fwd1_value = '0;
    fwd2_hit   = 1'b0;
    fwd2_value = '0;
    w_idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (CW'(i) < r_count) begin
        if ((rs1 != 5'd0) && (r_rd[w_idx] == rs1)) begin
          fwd1_hit   = 1'b1;
          fwd1_value = r_val[w_idx];
        end
        if ((rs2 != 5'd0) && (r_rd[w_idx] == rs2)) begin
          fwd2_hit   = 1'b1;
          fwd2_value = r_val[w_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: inputs change 1ns after a rising edge,
// outputs are checked 1ns later, well away from the next edge.
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_value;
  logic        wb_stall;
  logic        reg_we;
  logic [4:0]  rd;
  logic [31:0] rd_value;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fwd1_hit;
  logic [31:0] fwd1_value;
  logic        fwd2_hit;
  logic [31:0] fwd2_value;
  logic [2:0]  count;
  logic        idle;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_value(in_value),
    .wb_stall(wb_stall),
    .reg_we(reg_we), .rd(rd), .rd_value(rd_value),
    .rs1(rs1), .rs2(rs2),
    .fwd1_hit(fwd1_hit), .fwd1_value(fwd1_value),
    .fwd2_hit(fwd2_hit), .fwd2_value(fwd2_value),
    .count(count), .idle(idle)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_value = '0;
    wb_stall = 1'b0; rs1 = '0; rs2 = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_reg_we", 64'(reg_we), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_rd_value", 64'(rd_value), 64'd0);
    chk("rst_fwd1_hit", 64'(fwd1_hit), 64'd0);
    chk("rst_fwd2_value", 64'(fwd2_value), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_count", 64'(count), 64'd0);

    // Single write
    in_valid = 1'b1; in_rd = 5'd5; in_value = 32'hDEADBEEF;
    #1 chk("single_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0; rs1 = 5'd5;
    #1;
    chk("single_reg_we", 64'(reg_we), 64'd1);
    chk("single_rd", 64'(rd), 64'd5);
    chk("single_rd_value", 64'(rd_value), 64'hDEADBEEF);
    chk("single_fwd_on_pop", 64'(fwd1_hit), 64'd1);
    chk("single_fwd_value", 64'(fwd1_value), 64'hDEADBEEF);
    step();
    chk("single_idle", 64'(idle), 64'd1);
    chk("single_done_we", 64'(reg_we), 64'd0);
    chk("single_done_rd", 64'(rd), 64'd0);

    // x0 drop
    in_valid = 1'b1; in_rd = 5'd0; in_value = 32'h1234; rs1 = 5'd0;
    #1;
    chk("x0_in_ready", 64'(in_ready), 64'd1);
    chk("x0_fwd_hit", 64'(fwd1_hit), 64'd0);
    step();
    in_valid = 1'b0;
    #1;
    chk("x0_count", 64'(count), 64'd0);
    chk("x0_reg_we", 64'(reg_we), 64'd0);
    chk("x0_fwd_hit_after", 64'(fwd1_hit), 64'd0);

    // Fill under stall
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_rd = 5'(i); in_value = 32'(i * 'h11);
      step();
    end
    in_valid = 1'b1; in_rd = 5'd6; in_value = 32'h66;
    #1;
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_reg_we", 64'(reg_we), 64'd0);
    chk("fill_head_rd", 64'(rd), 64'd1);
    chk("fill_head_value", 64'(rd_value), 64'h11);
    step();
    in_valid = 1'b0; wb_stall = 1'b0;
    #1;
    chk("fill_rejected_count", 64'(count), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_reg_we", 64'(reg_we), 64'd1);
      chk("drain_rd", 64'(rd), 64'(i));
      chk("drain_rd_value", 64'(rd_value), 64'(i * 'h11));
      step();
    end
    chk("drain_idle", 64'(idle), 64'd1);

    // Forward youngest
    wb_stall = 1'b1;
    in_valid = 1'b1; in_rd = 5'd7; in_value = 32'hA;
    step();
    in_value = 32'hB;
    step();
    in_valid = 1'b0; rs1 = 5'd7; rs2 = 5'd8;
    #1;
    chk("fwd_hit1", 64'(fwd1_hit), 64'd1);
    chk("fwd_value1", 64'(fwd1_value), 64'hB);
    chk("fwd_hit2", 64'(fwd2_hit), 64'd0);
    chk("fwd_value2", 64'(fwd2_value), 64'd0);
    rs2 = 5'd0;
    #1 chk("fwd_rs0", 64'(fwd2_hit), 64'd0);
    wb_stall = 1'b0;
    #1;
    chk("fwd_pop1_we", 64'(reg_we), 64'd1);
    chk("fwd_pop1_value", 64'(rd_value), 64'hA);
    chk("fwd_pop1_fwd", 64'(fwd1_value), 64'hB);
    step();
    chk("fwd_pop2_value", 64'(rd_value), 64'hB);
    chk("fwd_pop2_hit", 64'(fwd1_hit), 64'd1);
    step();
    chk("fwd_clear_hit", 64'(fwd1_hit), 64'd0);
    chk("fwd_clear_value", 64'(fwd1_value), 64'd0);
    chk("fwd_idle", 64'(idle), 64'd1);

    // Full with simultaneous push/pop
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_rd = 5'(i); in_value = 32'('h100 + i);
      step();
    end
    wb_stall = 1'b0; in_rd = 5'd9; in_value = 32'h99;
    #1;
    chk("full_pp_in_ready", 64'(in_ready), 64'd1);
    chk("full_pp_reg_we", 64'(reg_we), 64'd1);
    chk("full_pp_rd", 64'(rd), 64'd1);
    step();
    in_valid = 1'b0;
    #1;
    chk("full_pp_count", 64'(count), 64'd4);
    chk("full_pp_next_rd", 64'(rd), 64'd2);
    step(); step(); step();
    chk("full_pp_tail_we", 64'(reg_we), 64'd1);
    chk("full_pp_tail_rd", 64'(rd), 64'd9);
    chk("full_pp_tail_value", 64'(rd_value), 64'h99);
    step();
    chk("full_pp_idle", 64'(idle), 64'd1);

    // Reset mid-operation
    wb_stall = 1'b1;
    for (int i = 10; i <= 12; i++) begin
      in_valid = 1'b1; in_rd = 5'(i); in_value = 32'(i);
      step();
    end
    in_valid = 1'b0; rs1 = 5'd10;
    #1;
    chk("rmid_count", 64'(count), 64'd3);
    rst = 1'b1; wb_stall = 1'b0;
    #1 chk("rmid_no_write_in_reset", 64'(reg_we), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rmid_count_after", 64'(count), 64'd0);
    chk("rmid_idle", 64'(idle), 64'd1);
    chk("rmid_reg_we", 64'(reg_we), 64'd0);
    chk("rmid_fwd_hit", 64'(fwd1_hit), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rmid_never_writes", 64'(reg_we), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-side initiator for the 32x32 integer register file (x0 hardwired zero, one write port, two combinational read ports).
- Accepts writeback results from execute/load over a valid/ready handshake and buffers them in a small in-order queue.
- Drains one entry per cycle into the register file write port (reg_we/rd/rd_value) unless stalled.
- Provides youngest-first forwarding so operand reads see queued-but-unwritten results.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- XLEN, 32, data width of results.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  producer has a result.
- in_ready  output  1  queue can accept this cycle.
- in_rd  input  5  destination register index.
- in_value  input  XLEN  result value.
- wb_stall  input  1  register file write port unavailable this cycle.
- reg_we  output  1  register file write enable.
- rd  output  5  register file write index.
- rd_value  output  XLEN  register file write data.
- rs1  input  5  operand 1 index being read this cycle.
- rs2  input  5  operand 2 index being read this cycle.
- fwd1_hit  output  1  rs1 matches a queued entry.
- fwd1_value  output  XLEN  youngest queued value for rs1.
- fwd2_hit  output  1  rs2 matches a queued entry.
- fwd2_value  output  XLEN  youngest queued value for rs2.
- count  output  $clog2(DEPTH)+1  current occupancy.
- idle  output  1  queue empty.

Behaviour:
- Storage: circular buffer of DEPTH entries {rd[4:0], value[XLEN-1:0]}, with head/tail pointers and an occupancy counter.
- Push: occurs when in_valid && in_ready && in_rd != 0, writing to the tail entry.
  - in_valid && in_ready && in_rd == 0 is accepted (handshake completes) but not enqueued; count is unchanged.
- in_ready = (count < DEPTH) || pop. A push to a full queue is allowed in the same cycle as a pop.
- Pop: pop = (count != 0) && !wb_stall.
- Write port outputs are combinational from the head entry:
  - reg_we = pop.
  - rd = head.rd and rd_value = head.value when count != 0; both are 0 when empty.
- Latency: a result accepted at edge N appears on reg_we in cycle N+1 when the queue was empty and there is no stall. The register file holds the value after edge N+1.
- Ordering: strictly in order. Two entries to the same rd are written oldest first, so the final register file value is the youngest.
- Count update: count' = count + push - pop. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- Forwarding (combinational):
  - fwdN_hit = 1 if rsN != 0 and any valid entry has rd == rsN.
  - fwdN_value = value of the youngest matching entry (closest to tail); 0 when no hit.
  - The head entry being popped this cycle still counts as a hit for that cycle.
  - The incoming in_* entry does not forward.
- rsN == 0 always gives hit = 0 and value = 0.
- wb_stall held high: queue fills, then in_ready = 0. Contents and outputs are stable except reg_we = 0.
- idle = (count == 0).
- Reset: count = 0, head = tail = 0, all entries invalid. Resulting outputs:
  - reg_we = 0, rd = 0, rd_value = 0.
  - fwd*_hit = 0, fwd*_value = 0.
  - in_ready = 1, idle = 1.
- Reset while stalled or full discards all queued entries; no write is issued in the reset cycle.
- Entry data registers need no reset; validity is derived from pointers and count only.

Test Plan:
- Single write: after reset push rd=5, value=0xDEADBEEF, no stall -> next cycle reg_we=1, rd=5, rd_value=0xDEADBEEF; the cycle after, idle=1.
- x0 drop: push rd=0, value=0x1234 -> in_ready=1 and handshake completes, count stays 0, reg_we never asserts, no forwarding hit for rs1=0.
- Fill under stall: wb_stall=1, push rd=1..4 with values 0x11..0x44 -> count=4, in_ready=0, reg_we=0. Release stall -> reg_we=1 for 4 consecutive cycles with rd=1,2,3,4 in order.
- Forward youngest: wb_stall=1, push rd=7/0xA then rd=7/0xB; rs1=7, rs2=8 -> fwd1_hit=1, fwd1_value=0xB, fwd2_hit=0. Release stall -> writes of 0xA then 0xB, and fwd1_hit clears after the second pop.
- Full with simultaneous push/pop: queue full, stall low, in_valid with rd=9/0x99 -> in_ready=1, count stays 4, head popped, rd=9 enqueued at tail and written 4 cycles later.
- Reset mid-operation: with 3 entries queued under stall, assert rst for 1 cycle -> count=0, idle=1, reg_we=0, and no queued write ever reaches the register file.
